muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits (even, >= 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  input  N  multiplicand / dividend.
REQ-007 SHALL have port b  input  N  multiplier / divisor.
REQ-008 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-009 SHALL have port done  output  1  single-cycle pulse: hi/lo just updated.
REQ-010 SHALL have port hi  output  N  HI result, held between operations.
REQ-011 SHALL have port lo  output  N  LO result, held between operations.
REQ-012 SHALL have port div_by_zero  output  1  last completed op was DIV/DIVU with b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on start; RUN->DONE after exactly N iterations; DONE->RUN on start, else DONE->IDLE.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN ignored, no operand capture.
REQ-015 SHALL capture op, a, b on the accepting edge; later input changes do not affect the result.
REQ-016 SHALL run one iterative step per cycle in RUN: shift-add multiply, restoring divide, on operand magnitudes; signed ops (MULT, DIV) take two's-complement magnitudes at capture.
REQ-017 SHALL have latency: start accepted at edge k -> hi/lo/div_by_zero written at edge k+N+1, done high for the following cycle only; N=32 gives 33 edges.
REQ-018 SHALL drive busy high in every cycle of RUN, low in IDLE and DONE.
REQ-019 SHALL leave hi, lo, div_by_zero unchanged except at the completion edge and reset.
REQ-020 MULT/MULTU: SHALL set {hi,lo} = full 2N-bit signed/unsigned product.
REQ-021 DIV/DIVU: SHALL set lo = quotient truncated toward zero, hi = remainder; for DIV the remainder sign equals the dividend sign.
REQ-022 SHALL, for DIV with a = most-negative and b = -1, give lo = most-negative, hi = 0, no flag.
REQ-023 SHALL, for DIV/DIVU with b == 0, give lo = all ones, hi = a, div_by_zero = 1, with the normal latency.
REQ-024 SHALL clear div_by_zero at completion of any op without a zero divisor.
REQ-025 SHALL, on start in DONE, complete the new op at the normal latency; back-to-back done pulses are N+1 cycles apart.

Reset
REQ-026 SHALL, when rst low at a clk edge, enter IDLE with busy=0, done=0, hi=0, lo=0, div_by_zero=0.
REQ-027 SHALL abort any in-progress op on reset: no done pulse, no result written.
REQ-028 SHALL ignore start while rst low; a start sampled with rst high on the next edge is accepted normally.

Verification
REQ-029 SHALL cover: MULT a=FFFFFFFF b=00000002 -> hi=FFFFFFFF lo=FFFFFFFE; MULTU same -> hi=00000001 lo=FFFFFFFE; done exactly 33 edges after start.
REQ-030 SHALL cover: DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU a=00000064 b=00000007 -> lo=0000000E hi=00000002.
REQ-031 SHALL cover: DIVU a=00000064 b=0 -> lo=FFFFFFFF hi=00000064 div_by_zero=1; then MULT 3*3 -> lo=00000009 hi=0 div_by_zero=0.
REQ-032 SHALL cover: DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000 div_by_zero=0.
REQ-033 SHALL cover: start pulsed at RUN iteration 5 with different a,b -> ignored, first op result unchanged; start held high through DONE -> second op starts, done pulses 33 cycles apart.
REQ-034 SHALL cover: rst low at RUN iteration 10 -> next cycle busy=0 hi=0 lo=0, no done for 40 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative MIPS-style multiply/divide unit.
//           Shift-add multiply, restoring divide, one step per clock.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         div_by_zero
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]   r_state;
   logic [1:0]   w_next;
   logic [CW-1:0] r_cnt;
   logic         r_is_div;
   logic         r_zdiv;
   logic         r_neg_lo;
   logic         r_neg_hi;
   logic [N-1:0] r_acc;
   logic [N-1:0] r_mq;
   logic [N-1:0] r_opnd;
   logic [N-1:0] r_hi;
   logic [N-1:0] r_lo;
   logic         r_dbz;
   logic         r_done;

   logic         w_accept;
   logic         w_sa;
   logic         w_sb;
   logic [N-1:0] w_a_mag;
   logic [N-1:0] w_b_mag;
   logic [N:0]   w_sum;
   logic [N:0]   w_shift;
   logic         w_ge;
   logic [N-1:0] w_diff;
   logic [2*N-1:0] w_prod;
   logic [2*N-1:0] w_prod_s;
   logic [N-1:0] w_quo;
   logic [N-1:0] w_rem;
   logic [N-1:0] w_res_hi;
   logic [N-1:0] w_res_lo;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? S_RUN : S_IDLE;
         S_RUN:   w_next = (r_cnt == c_LAST) ? S_DONE : S_RUN;
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (r_state == S_RUN);
      done        = r_done;
      hi          = r_hi;
      lo          = r_lo;
      div_by_zero = r_dbz;
   end

   // ---------------------------------------------------------------- datapath
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_sa     = ~op[0] & a[N-1];
   assign w_sb     = ~op[0] & b[N-1];
   assign w_a_mag  = w_sa ? -a : a;
   assign w_b_mag  = w_sb ? -b : b;

   // Multiply step: conditional add, then shift {acc,mq} right by one.
   assign w_sum   = {1'b0, r_acc} + {1'b0, r_opnd};
   // Divide step: remainder < divisor, so the low N bits of the difference suffice.
   assign w_shift = {r_acc, r_mq[N-1]};
   assign w_ge    = (w_shift >= {1'b0, r_opnd});
   assign w_diff  = w_shift[N-1:0] - r_opnd;

   assign w_prod   = {r_acc, r_mq};
   assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
   assign w_quo    = r_neg_lo ? -r_mq : r_mq;
   assign w_rem    = r_neg_hi ? -r_acc : r_acc;

   // With a zero divisor the remainder converges to |a|, so w_rem restores a.
   always_comb begin
      w_res_hi = w_prod_s[2*N-1:N];
      w_res_lo = w_prod_s[N-1:0];
      if (r_is_div) begin
         w_res_hi = w_rem;
         w_res_lo = r_zdiv ? {N{1'b1}} : w_quo;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_zdiv   <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_acc    <= '0;
         r_mq     <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dbz    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_hi  <= w_res_hi;
            r_lo  <= w_res_lo;
            r_dbz <= r_zdiv;
         end
         if (w_accept) begin
            r_is_div <= op[1];
            r_zdiv   <= op[1] && (b == '0);
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa;
            r_acc    <= '0;
            r_mq     <= w_a_mag;
            r_opnd   <= w_b_mag;
            r_cnt    <= '0;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
               r_acc <= w_ge ? w_diff : w_shift[N-1:0];
               r_mq  <= {r_mq[N-2:0], w_ge};
            end else if (r_mq[0]) begin
               r_acc <= w_sum[N:1];
               r_mq  <= {w_sum[0], r_mq[N-1:1]};
            end else begin
               r_acc <= {1'b0, r_acc[N-1:1]};
               r_mq  <= {r_acc[0], r_mq[N-1:1]};
            end
         end
      end
   end

endmodule

`default_nettype wire
